// File: rtl/mpu_pkg.sv
// Shared types and helpers for the MPU permutation-expansion determinant unit.
// The bench uses the same offset and latency functions.
package mpu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_MAX_N  = 5;
    localparam int DEF_ACC_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MUL  = 3'd2,
        ST_ACC  = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Bit offset of element (row, col) inside the row-major matrix bus.
    function automatic int at(input int row, input int col,
                              input int data_w = DEF_DATA_W,
                              input int max_n  = DEF_MAX_N);
        return data_w * (col + max_n * row);
    endfunction

    function automatic int factorial(input int n);
        int f;
        f = 1;
        for (int i = 2; i <= n; i++) begin
            f = f * i;
        end
        return f;
    endfunction

    // Edges from the start-sampling edge to the edge that raises done.
    function automatic int det_latency(input int n, input int max_n = DEF_MAX_N);
        if (n < 1 || n > max_n) begin
            return 1;
        end else begin
            return factorial(n) * (n + 2) + 1;
        end
    endfunction

    // Two's-complement overflow of s = a + b (sub=0) or s = a - b (sub=1), from sign bits.
    function automatic logic add_overflow(input logic a_sign, input logic b_sign,
                                          input logic s_sign, input logic sub);
        logic b_eff;
        b_eff = sub ? ~b_sign : b_sign;
        return (a_sign == b_eff) && (s_sign != a_sign);
    endfunction

endpackage

// File: rtl/mpu_lehmer_perm.sv
// Mixed-radix Lehmer digit counter plus combinational permutation decoder.
// Digit k has radix n-k; the last digit is least significant.
module mpu_lehmer_perm
    import mpu_pkg::*;
#(
    parameter  int MAX_N = DEF_MAX_N,
    localparam int IW    = $clog2(MAX_N),
    localparam int SW    = $clog2(MAX_N + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         incr,
    input  logic [SW-1:0]                n,
    output logic [MAX_N-1:0][IW-1:0]     perm,
    output logic                         parity,
    output logic                         last
);

    logic [MAX_N-1:0][IW-1:0] digits_r;
    logic [MAX_N-1:0][IW-1:0] digits_next_s;

    // Inversion count parity equals permutation parity.
    function automatic logic digit_parity(input logic [MAX_N-1:0][IW-1:0] d);
        logic p;
        p = 1'b0;
        for (int k = 0; k < MAX_N; k++) begin
            p = p ^ d[k][0];
        end
        return p;
    endfunction

    // Digit register: cleared on reset or clear, stepped on incr.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            digits_r <= '0;
        end else if (incr) begin
            digits_r <= digits_next_s;
        end else begin
            digits_r <= digits_r;
        end
    end

    // Ripple-carry increment from the least significant digit upward.
    always_comb begin : inc_blk
        logic carry;
        digits_next_s = digits_r;
        carry         = 1'b1;
        for (int k = MAX_N - 1; k >= 0; k--) begin
            if (carry && (k < int'(n))) begin
                if (int'(digits_r[k]) == int'(n) - 1 - k) begin
                    digits_next_s[k] = '0;
                end else begin
                    digits_next_s[k] = digits_r[k] + IW'(1'b1);
                    carry            = 1'b0;
                end
            end else begin
                digits_next_s[k] = digits_r[k];
            end
        end
    end

    // Last permutation: every active digit sits at its maximum n-1-k.
    always_comb begin
        last = 1'b1;
        for (int k = 0; k < MAX_N; k++) begin
            if ((k < int'(n)) && (int'(digits_r[k]) != int'(n) - 1 - k)) begin
                last = 1'b0;
            end else begin
                last = last;
            end
        end
    end

    // p[k] is the d[k]-th smallest column not taken by earlier rows.
    always_comb begin : dec_blk
        logic [MAX_N-1:0] used;
        int               cnt;
        logic             found;
        used = '0;
        perm = '0;
        for (int k = 0; k < MAX_N; k++) begin
            cnt   = 0;
            found = 1'b0;
            if (k < int'(n)) begin
                for (int c = 0; c < MAX_N; c++) begin
                    if (!used[c] && !found) begin
                        if (cnt == int'(digits_r[k])) begin
                            perm[k] = IW'(c);
                            used[c] = 1'b1;
                            found   = 1'b1;
                        end else begin
                            cnt = cnt + 1;
                        end
                    end else begin
                        cnt = cnt;
                    end
                end
            end else begin
                perm[k] = '0;
            end
        end
    end

    assign parity = digit_parity(digits_r);

endmodule

// File: rtl/mpu_det_perm.sv
// Exact signed determinant by Leibniz expansion over all permutations,
// one time-shared multiplier, permutations from a Lehmer counter.
module mpu_det_perm
    import mpu_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int MAX_N  = DEF_MAX_N,
    parameter  int ACC_W  = DEF_ACC_W,
    localparam int SW     = $clog2(MAX_N + 1)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [SW-1:0]                     size,
    input  logic [DATA_W*MAX_N*MAX_N-1:0]     matrix,
    output logic signed [ACC_W-1:0]           result,
    output logic                              done,
    output logic                              busy,
    output logic                              overflow,
    output logic                              error
);

    localparam int IW = $clog2(MAX_N);
    localparam int PW = DATA_W * MAX_N;
    localparam int MW = DATA_W * MAX_N * MAX_N;
    localparam int EW = PW + ACC_W;

    state_t                   state_r, state_next_s;
    logic [MW-1:0]            matrix_r, matrix_next_s;
    logic [SW-1:0]            size_r, size_next_s;
    logic [IW-1:0]            k_r, k_next_s;
    logic signed [PW-1:0]     product_r, product_next_s;
    logic signed [ACC_W-1:0]  acc_r, acc_next_s;
    logic signed [ACC_W-1:0]  result_r, result_next_s;
    logic                     done_r, done_next_s;
    logic                     busy_r, busy_next_s;
    logic                     overflow_r, overflow_next_s;
    logic                     error_r, error_next_s;

    logic                     lehmer_clear_s;
    logic                     lehmer_incr_s;
    logic [MAX_N-1:0][IW-1:0] perm_s;
    logic                     parity_s;
    logic                     last_s;

    logic signed [DATA_W-1:0] elem_s [MAX_N][MAX_N];
    logic [IW-1:0]            cur_col_s;
    logic signed [DATA_W-1:0] cur_elem_s;
    logic signed [PW-1:0]     elem_ext_s;
    logic signed [PW-1:0]     mul_s;
    logic signed [ACC_W-1:0]  term_s;
    logic signed [ACC_W-1:0]  sum_s;
    logic                     term_fits_s;
    logic                     sum_ovf_s;
    logic                     size_valid_s;
    logic                     last_row_s;

    mpu_lehmer_perm #(
        .MAX_N (MAX_N)
    ) u_lehmer (
        .clock  (clock),
        .reset  (reset),
        .clear  (lehmer_clear_s),
        .incr   (lehmer_incr_s),
        .n      (size_r),
        .perm   (perm_s),
        .parity (parity_s),
        .last   (last_s)
    );

    for (genvar r = 0; r < MAX_N; r++) begin : g_row
        for (genvar c = 0; c < MAX_N; c++) begin : g_col
            assign elem_s[r][c] = matrix_r[at(r, c, DATA_W, MAX_N) +: DATA_W];
        end
    end

    assign cur_col_s  = perm_s[k_r];
    assign cur_elem_s = elem_s[k_r][cur_col_s];
    assign elem_ext_s = PW'(cur_elem_s);
    assign mul_s      = product_r * elem_ext_s;

    // The product is exact at PW bits; it is narrowed only when accumulated.
    assign term_s      = ACC_W'(product_r);
    assign term_fits_s = (EW'(term_s) == EW'(product_r));
    assign sum_s       = parity_s ? (acc_r - term_s) : (acc_r + term_s);
    assign sum_ovf_s   = add_overflow(acc_r[ACC_W-1], term_s[ACC_W-1], sum_s[ACC_W-1], parity_s);

    assign size_valid_s = (size_r != '0) && (int'(size_r) <= MAX_N);
    assign last_row_s   = (int'(k_r) == int'(size_r) - 1);

    // Next-state and next-register values for the operation sequencer.
    always_comb begin
        state_next_s    = state_r;
        matrix_next_s   = matrix_r;
        size_next_s     = size_r;
        k_next_s        = k_r;
        product_next_s  = product_r;
        acc_next_s      = acc_r;
        result_next_s   = result_r;
        done_next_s     = done_r;
        busy_next_s     = busy_r;
        overflow_next_s = overflow_r;
        error_next_s    = error_r;
        lehmer_clear_s  = 1'b0;
        lehmer_incr_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    matrix_next_s   = matrix;
                    size_next_s     = size;
                    result_next_s   = '0;
                    done_next_s     = 1'b0;
                    overflow_next_s = 1'b0;
                    error_next_s    = 1'b0;
                    busy_next_s     = 1'b1;
                    state_next_s    = ST_LOAD;
                end else begin
                    state_next_s    = state_r;
                end
            end
            ST_LOAD: begin
                if (!size_valid_s) begin
                    error_next_s  = 1'b1;
                    result_next_s = '0;
                    done_next_s   = 1'b1;
                    busy_next_s   = 1'b0;
                    state_next_s  = ST_DONE;
                end else begin
                    acc_next_s     = '0;
                    lehmer_clear_s = 1'b1;
                    product_next_s = PW'(1'b1);
                    k_next_s       = '0;
                    state_next_s   = ST_MUL;
                end
            end
            ST_MUL: begin
                product_next_s = mul_s;
                if (last_row_s) begin
                    state_next_s = ST_ACC;
                end else begin
                    k_next_s     = k_r + IW'(1'b1);
                end
            end
            ST_ACC: begin
                acc_next_s   = sum_s;
                state_next_s = ST_NEXT;
                if (!term_fits_s || sum_ovf_s) begin
                    overflow_next_s = 1'b1;
                end else begin
                    overflow_next_s = overflow_r;
                end
            end
            ST_NEXT: begin
                if (last_s) begin
                    result_next_s = acc_r;
                    done_next_s   = 1'b1;
                    busy_next_s   = 1'b0;
                    state_next_s  = ST_DONE;
                end else begin
                    lehmer_incr_s  = 1'b1;
                    product_next_s = PW'(1'b1);
                    k_next_s       = '0;
                    state_next_s   = ST_MUL;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            matrix_r   <= '0;
            size_r     <= '0;
            k_r        <= '0;
            product_r  <= '0;
            acc_r      <= '0;
            result_r   <= '0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            matrix_r   <= matrix_next_s;
            size_r     <= size_next_s;
            k_r        <= k_next_s;
            product_r  <= product_next_s;
            acc_r      <= acc_next_s;
            result_r   <= result_next_s;
            done_r     <= done_next_s;
            busy_r     <= busy_next_s;
            overflow_r <= overflow_next_s;
            error_r    <= error_next_s;
        end
    end

    assign result   = result_r;
    assign done     = done_r;
    assign busy     = busy_r;
    assign overflow = overflow_r;
    assign error    = error_r;

endmodule

// File: tb/tb_mpu_det_perm.sv
// Directed bench for mpu_det_perm: hand-computed determinants, latencies and flags.
module tb_mpu_det_perm;
    import mpu_pkg::*;

    localparam int DATA_W = 8;
    localparam int MAX_N  = 5;
    localparam int ACC_W  = 32;
    localparam int SW     = $clog2(MAX_N + 1);
    localparam int MW     = DATA_W * MAX_N * MAX_N;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     start;
    logic [SW-1:0]            size;
    logic [MW-1:0]            matrix;
    logic signed [ACC_W-1:0]  result;
    logic                     done;
    logic                     busy;
    logic                     overflow;
    logic                     error;

    logic [MW-1:0] mat;
    int checks_total  = 0;
    int checks_passed = 0;

    mpu_det_perm #(
        .DATA_W (DATA_W),
        .MAX_N  (MAX_N),
        .ACC_W  (ACC_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .size     (size),
        .matrix   (matrix),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .overflow (overflow),
        .error    (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input longint got, input longint exp);
        checks_total++;
        if (got == exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_el(input int r, input int c, input int v);
        mat[at(r, c) +: DATA_W] = DATA_W'(v);
    endtask

    task automatic load_identity(input int n);
        mat = '0;
        for (int i = 0; i < n; i++) begin
            set_el(i, i, 1);
        end
    endtask

    // Issue start (sampled at edge 0), then count edges until done.
    // poke_edge > 0 pulses a stray start so it is sampled at that edge.
    task automatic run_op(input string tag, input int n, input longint exp_res,
                          input bit exp_ovf, input bit exp_err, input int exp_lat,
                          input int poke_edge);
        int edges;
        size   = SW'(n);
        matrix = mat;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start  = 1'b0;
        matrix = ~mat;
        size   = SW'(2);
        check({tag, " busy@0"}, busy, 1);
        check({tag, " done@0"}, done, 0);
        edges = 0;
        while (!done && edges < 2000) begin
            start = (edges + 1 == poke_edge) ? 1'b1 : 1'b0;
            @(posedge clock);
            #1;
            edges++;
        end
        start = 1'b0;
        check({tag, " latency"}, edges, exp_lat);
        check({tag, " result"}, result, exp_res);
        check({tag, " overflow"}, overflow, exp_ovf);
        check({tag, " error"}, error, exp_err);
        check({tag, " busy_end"}, busy, 0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        size   = '0;
        matrix = '0;
        mat    = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst result", result, 0);
        check("rst done", done, 0);
        check("rst busy", busy, 0);
        check("rst overflow", overflow, 0);
        check("rst error", error, 0);

        // Reset together with start: reset wins.
        start = 1'b1;
        size  = SW'(2);
        @(posedge clock);
        #1;
        check("rst+start busy", busy, 0);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clock);
        #1;

        mat = '0;
        set_el(0, 0, 3); set_el(0, 1, 8);
        set_el(1, 0, 4); set_el(1, 1, 6);
        run_op("n2", 2, -14, 1'b0, 1'b0, 9, 0);

        mat = '0;
        set_el(0, 0, 6); set_el(0, 1, 1);  set_el(0, 2, 1);
        set_el(1, 0, 4); set_el(1, 1, -2); set_el(1, 2, 5);
        set_el(2, 0, 2); set_el(2, 1, 8);  set_el(2, 2, 7);
        run_op("n3", 3, -306, 1'b0, 1'b0, 31, 0);

        load_identity(5);
        run_op("id5", 5, 1, 1'b0, 1'b0, 841, 0);

        // Started straight from DONE.
        mat = '0;
        set_el(0, 1, 1); set_el(1, 0, 1);
        set_el(2, 2, 1); set_el(3, 3, 1); set_el(4, 4, 1);
        run_op("swap5", 5, -1, 1'b0, 1'b0, 841, 0);

        load_identity(5);
        run_op("size0", 0, 0, 1'b0, 1'b1, 1, 0);
        run_op("size6", 6, 0, 1'b0, 1'b1, 1, 0);

        // |product| = 2^35 each; signed sum cancels to zero.
        mat = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                set_el(r, c, -128);
            end
        end
        run_op("neg128", 5, 0, 1'b1, 1'b0, 841, 200);

        // Reset sampled at edge 100 of a running N=5 operation.
        load_identity(5);
        size   = SW'(5);
        matrix = mat;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (99) @(posedge clock);
        #1;
        check("midrst busy_before", busy, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst result", result, 0);
        check("midrst overflow", overflow, 0);
        reset = 1'b0;

        mat = '0;
        set_el(0, 0, 3); set_el(0, 1, 8);
        set_el(1, 0, 4); set_el(1, 1, 6);
        run_op("n2_after", 2, -14, 1'b0, 1'b0, 9, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
